// File: rtl/axi_bw_sched_pkg.sv
// rtl/axi_bw_sched_pkg.sv - AW/B scheduler state type and response constants
package axi_bw_sched_pkg;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_FWD   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERR   = 2'd3
    } sched_state_e;

    // Response code the B-channel injector returns for a decode miss.
    localparam logic [1:0] B_RESP_DECERR = axi_pkg::RESP_DECERR;

endpackage

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI response encodings
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_aw_rr_picker.sv
// rtl/axi_aw_rr_picker.sv - combinational round-robin picker starting at ptr
module axi_aw_rr_picker #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then map back.
    always_comb begin
        valid = |req;
        rot   = N_REQ'({req, req} >> ptr);
        off   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IDX_W+1)'(N_REQ)) begin
            sum = sum - (IDX_W+1)'(N_REQ);
        end
        idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/axi_aw_bw_scheduler.sv
// rtl/axi_aw_bw_scheduler.sv - AW arbiter with outstanding-write throttle and DECERR drain
module axi_aw_bw_scheduler
    import axi_bw_sched_pkg::*;
#(
    parameter int N_TARG_PORT = 4,
    parameter int AXI_ID_IN   = 4,
    parameter int AXI_USER_W  = 6,
    parameter int CNT_W       = 4,
    localparam int PTR_W      = $clog2(N_TARG_PORT),
    localparam int AXI_ID_OUT = AXI_ID_IN + $clog2(N_TARG_PORT)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [N_TARG_PORT-1:0]                  awvalid_i,
    input  logic [N_TARG_PORT-1:0][AXI_ID_IN-1:0]   awid_i,
    input  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]  awuser_i,
    input  logic [N_TARG_PORT-1:0]                  awdecerr_i,
    output logic [N_TARG_PORT-1:0]                  awready_o,
    output logic                                    aw_valid_o,
    output logic [AXI_ID_OUT-1:0]                   aw_id_o,
    output logic [AXI_USER_W-1:0]                   aw_user_o,
    input  logic                                    aw_ready_i,
    input  logic                                    b_done_i,
    output logic                                    error_req_o,
    output logic [AXI_ID_IN-1:0]                    error_id_o,
    output logic [AXI_USER_W-1:0]                   error_user_o,
    input  logic                                    error_done_i,
    output logic                                    outstanding_o,
    output logic                                    full_o
);

    sched_state_e          state_q;
    logic [PTR_W-1:0]      ptr_q;
    logic [PTR_W-1:0]      sel_q;
    logic [AXI_ID_IN-1:0]  id_q;
    logic [AXI_USER_W-1:0] user_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  pick_valid;
    logic [PTR_W-1:0]      pick_idx;
    logic                  aw_hs;
    logic                  b_dec;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_TARG_PORT - 1)) ? '0 : p + 1'b1;
    endfunction

    axi_aw_rr_picker #(
        .N_REQ (N_TARG_PORT)
    ) u_picker (
        .req   (awvalid_i),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign full_o        = &cnt_q;
    assign outstanding_o = |cnt_q;
    assign aw_hs         = (state_q == ST_FWD) && aw_ready_i;
    // A B completion with nothing outstanding is spurious and dropped.
    assign b_dec         = b_done_i && (cnt_q != '0);

    // Arbitration / forwarding / decode-error sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ARB;
            ptr_q   <= '0;
            sel_q   <= '0;
            id_q    <= '0;
            user_q  <= '0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (pick_valid) begin
                        // Decode misses still need draining even when throttled.
                        if (awdecerr_i[pick_idx]) begin
                            sel_q   <= pick_idx;
                            id_q    <= awid_i[pick_idx];
                            user_q  <= awuser_i[pick_idx];
                            state_q <= ST_DRAIN;
                        end else if (!full_o) begin
                            sel_q   <= pick_idx;
                            id_q    <= awid_i[pick_idx];
                            user_q  <= awuser_i[pick_idx];
                            state_q <= ST_FWD;
                        end
                    end
                end
                ST_FWD: begin
                    if (aw_ready_i) begin
                        ptr_q   <= wrap_inc(sel_q);
                        state_q <= ST_ARB;
                    end
                end
                ST_DRAIN: begin
                    // DECERR must not overtake older writes' B responses.
                    if (cnt_q == '0) begin
                        state_q <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    if (error_done_i) begin
                        ptr_q   <= wrap_inc(sel_q);
                        state_q <= ST_ARB;
                    end
                end
                default: state_q <= ST_ARB;
            endcase
        end
    end

    // Outstanding-write counter: +1 per AW handshake, -1 per B, hold when both.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (aw_hs && !b_dec) begin
            if (!full_o) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (b_dec && !aw_hs) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Output decode from state; anything the state does not drive stays 0.
    always_comb begin
        awready_o    = '0;
        aw_valid_o   = 1'b0;
        aw_id_o      = '0;
        aw_user_o    = '0;
        error_req_o  = 1'b0;
        error_id_o   = '0;
        error_user_o = '0;
        case (state_q)
            ST_FWD: begin
                aw_valid_o       = 1'b1;
                aw_id_o          = {sel_q, id_q};
                aw_user_o        = user_q;
                awready_o[sel_q] = aw_ready_i;
            end
            ST_ERR: begin
                error_req_o      = 1'b1;
                error_id_o       = id_q;
                error_user_o     = user_q;
                awready_o[sel_q] = error_done_i;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_axi_aw_bw_scheduler.sv
// tb/tb_axi_aw_bw_scheduler.sv - self-checking bench for axi_aw_bw_scheduler
module tb_axi_aw_bw_scheduler;

    localparam int N    = 4;
    localparam int IDW  = 4;
    localparam int UW   = 6;
    localparam int CW   = 2;
    localparam int IDO  = 6;
    localparam int CMAX = (1 << CW) - 1;

    localparam int M_ARB   = 0;
    localparam int M_FWD   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_ERR   = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N-1:0]             awvalid_i;
    logic [N-1:0][IDW-1:0]    awid_i;
    logic [N-1:0][UW-1:0]     awuser_i;
    logic [N-1:0]             awdecerr_i;
    logic [N-1:0]             awready_o;
    logic                     aw_valid_o;
    logic [IDO-1:0]           aw_id_o;
    logic [UW-1:0]            aw_user_o;
    logic                     aw_ready_i;
    logic                     b_done_i;
    logic                     error_req_o;
    logic [IDW-1:0]           error_id_o;
    logic [UW-1:0]            error_user_o;
    logic                     error_done_i;
    logic                     outstanding_o;
    logic                     full_o;

    int errors = 0;
    int checks = 0;
    bit rand_ids = 1'b0;

    int m_mode, m_ptr, m_sel, m_cnt;
    logic [IDW-1:0] m_id;
    logic [UW-1:0]  m_user;

    always #5 clk = ~clk;

    axi_aw_bw_scheduler #(
        .N_TARG_PORT (N),
        .AXI_ID_IN   (IDW),
        .AXI_USER_W  (UW),
        .CNT_W       (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .awvalid_i     (awvalid_i),
        .awid_i        (awid_i),
        .awuser_i      (awuser_i),
        .awdecerr_i    (awdecerr_i),
        .awready_o     (awready_o),
        .aw_valid_o    (aw_valid_o),
        .aw_id_o       (aw_id_o),
        .aw_user_o     (aw_user_o),
        .aw_ready_i    (aw_ready_i),
        .b_done_i      (b_done_i),
        .error_req_o   (error_req_o),
        .error_id_o    (error_id_o),
        .error_user_o  (error_user_o),
        .error_done_i  (error_done_i),
        .outstanding_o (outstanding_o),
        .full_o        (full_o)
    );

    typedef struct {
        logic [N-1:0]   v;
        logic [N-1:0]   de;
        logic           rdy;
        logic           bd;
        logic           ed;
        logic           e_valid;
        logic [IDO-1:0] e_id;
        logic [N-1:0]   e_awready;
        logic           e_outst;
        logic           e_full;
        logic           e_err;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_fixed_ids();
        for (int p = 0; p < N; p++) begin
            awid_i[p]   = IDW'(p * 3 + 1);
            awuser_i[p] = UW'(16 + p);
        end
    endtask

    // Drive one cycle's inputs just after the edge, then wait to the sample point.
    task automatic step(input logic r, input logic [N-1:0] v, input logic [N-1:0] de,
                        input logic rdy, input logic bd, input logic ed);
        @(posedge clk);
        #1;
        rst          = r;
        awvalid_i    = v;
        awdecerr_i   = de;
        aw_ready_i   = rdy;
        b_done_i     = bd;
        error_done_i = ed;
        if (rand_ids) begin
            awid_i   = (N*IDW)'($urandom);
            awuser_i = (N*UW)'($urandom);
        end
        #3;
    endtask

    task automatic model_reset();
        m_mode = M_ARB;
        m_ptr  = 0;
        m_sel  = 0;
        m_cnt  = 0;
        m_id   = '0;
        m_user = '0;
    endtask

    function automatic logic [29:0] model_expect();
        logic           ev, ee;
        logic [IDO-1:0] eid;
        logic [UW-1:0]  eu, eeu;
        logic [N-1:0]   ear;
        logic [IDW-1:0] eeid;
        logic [1:0]     s2;
        s2   = 2'(m_sel);
        ev   = (m_mode == M_FWD);
        ee   = (m_mode == M_ERR);
        eid  = ev ? {s2, m_id} : '0;
        eu   = ev ? m_user : '0;
        eeid = ee ? m_id : '0;
        eeu  = ee ? m_user : '0;
        ear  = '0;
        if (ev && aw_ready_i)   ear[m_sel] = 1'b1;
        if (ee && error_done_i) ear[m_sel] = 1'b1;
        return {ev, eid, eu, ear, (m_cnt != 0), (m_cnt == CMAX), ee, eeid, eeu};
    endfunction

    task automatic model_update();
        bit inc, dec, found;
        int win;
        if (rst) begin
            model_reset();
            return;
        end
        inc   = (m_mode == M_FWD) && aw_ready_i;
        dec   = b_done_i && (m_cnt > 0);
        found = 1'b0;
        win   = 0;
        case (m_mode)
            M_ARB: begin
                for (int k = 0; k < N; k++) begin
                    if (!found && awvalid_i[(m_ptr + k) % N]) begin
                        found = 1'b1;
                        win   = (m_ptr + k) % N;
                    end
                end
                if (found && (awdecerr_i[win] || m_cnt < CMAX)) begin
                    m_sel  = win;
                    m_id   = awid_i[win];
                    m_user = awuser_i[win];
                    m_mode = awdecerr_i[win] ? M_DRAIN : M_FWD;
                end
            end
            M_FWD: if (aw_ready_i) begin
                m_ptr  = (m_sel + 1) % N;
                m_mode = M_ARB;
            end
            M_DRAIN: if (m_cnt == 0) m_mode = M_ERR;
            default: if (error_done_i) begin
                m_ptr  = (m_sel + 1) % N;
                m_mode = M_ARB;
            end
        endcase
        if (inc && !dec) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
        else if (dec && !inc) m_cnt = m_cnt - 1;
    endtask

    initial begin
        bit granted;
        int pulses;
        logic [29:0] exp_b;

        rst = 1'b1; awvalid_i = '0; awdecerr_i = '0; aw_ready_i = 1'b0;
        b_done_i = 1'b0; error_done_i = 1'b0;
        set_fixed_ids();

        //                 v      de    rdy   bd    ed    vld   id     awrdy   out   full  err
        tbl[0]  = '{4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 6'h01, 4'b0001, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 4'b0000, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h14, 4'b0010, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 4'b0000, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h27, 4'b0100, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 4'b0000, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h3a, 4'b1000, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 4'b0000, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h01, 4'b0001, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 4'b0000, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 4'b0000, 1'b0, 1'b0, 1'b0};

        // Reset with busy-looking inputs: everything must read 0.
        step(1'b1, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1);
        check("reset_outputs",
              {awready_o, aw_valid_o, aw_id_o, aw_user_o, error_req_o, error_id_o,
               error_user_o, outstanding_o, full_o}, '0);

        // Round-robin order, same-cycle inc/dec hold, b_done at zero ignored.
        for (int i = 0; i < 13; i++) begin
            step(1'b0, tbl[i].v, tbl[i].de, tbl[i].rdy, tbl[i].bd, tbl[i].ed);
            check($sformatf("table_row%0d", i),
                  {aw_valid_o, aw_id_o, awready_o, outstanding_o, full_o, error_req_o},
                  {tbl[i].e_valid, tbl[i].e_id, tbl[i].e_awready, tbl[i].e_outst,
                   tbl[i].e_full, tbl[i].e_err});
        end

        // Throttle: three AWs fill a 2-bit counter; the fourth waits for a B.
        step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 4'b0001, 4'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'b0001, 4'h0, 1'b1, 1'b0, 1'b0);
        check("full_after_3", {full_o, outstanding_o, aw_valid_o}, 3'b110);
        step(1'b0, 4'b0001, 4'h0, 1'b1, 1'b0, 1'b0);
        check("full_blocks_grant", {aw_valid_o, awready_o}, 5'b0);
        step(1'b0, 4'b0001, 4'h0, 1'b1, 1'b1, 1'b0);
        check("full_blocks_grant2", {aw_valid_o, full_o}, 2'b01);
        step(1'b0, 4'b0001, 4'h0, 1'b1, 1'b0, 1'b0);
        check("b_frees_slot", {full_o, outstanding_o, aw_valid_o}, 3'b010);
        granted = 1'b0;
        for (int i = 0; i < 4 && !granted; i++) begin
            step(1'b0, 4'b0001, 4'h0, 1'b1, 1'b0, 1'b0);
            if (aw_valid_o) granted = 1'b1;
        end
        check("fourth_aw_forwarded", granted, 1'b1);

        // Decode error on port 2 with two writes outstanding.
        step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0001, 4'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
        check("drain_cnt2", {aw_valid_o, error_req_o, outstanding_o}, 3'b001);
        step(1'b0, 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0);
        check("drain_after_b1", error_req_o, 1'b0);
        step(1'b0, 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0);
        check("drain_after_b2", error_req_o, 1'b0);
        step(1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
        check("drain_cnt0", {error_req_o, outstanding_o}, 2'b00);
        pulses = 0;
        step(1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
        pulses += int'(awready_o[2]);
        check("err_req", {error_req_o, error_id_o, error_user_o, awready_o},
              {1'b1, 4'd7, 6'h12, 4'b0000});
        step(1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1);
        pulses += int'(awready_o[2]);
        check("err_done_awready", {error_req_o, awready_o}, {1'b1, 4'b0100});
        step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        pulses += int'(awready_o[2]);
        check("err_single_pulse", pulses, 1);
        check("err_cleared", {error_req_o, awready_o}, 5'b0);

        // Reset in the middle of a stalled forward.
        step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'b0010, 4'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'b0010, 4'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'b0010, 4'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'b0010, 4'h0, 1'b0, 1'b0, 1'b0);
        check("stalled_fwd", {aw_valid_o, outstanding_o, awready_o}, {1'b1, 1'b1, 4'b0000});
        step(1'b1, 4'b0010, 4'h0, 1'b0, 1'b0, 1'b0);
        check("fwd_rst_cycle_no_ready", awready_o, 4'b0000);
        step(1'b0, 4'b0010, 4'h0, 1'b0, 1'b0, 1'b0);
        check("post_rst", {aw_valid_o, outstanding_o, awready_o}, 6'b0);

        // Randomized run against the reference model.
        rand_ids = 1'b1;
        step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] de;
            de = '0;
            for (int p = 0; p < N; p++) de[p] = ($urandom_range(0, 7) == 0);
            step(($urandom_range(0, 199) == 0), N'($urandom), de,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)));
            exp_b = model_expect();
            check($sformatf("rand_cycle%0d", c),
                  {aw_valid_o, aw_id_o, aw_user_o, awready_o, outstanding_o, full_o,
                   error_req_o, error_id_o, error_user_o}, exp_b);
            model_update();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
